inst_mem_sync: RTL and testbench
================================

# inst_mem_sync

Synchronous, parametrised instruction memory for the IF stage of the pipeline CPU.
- Replaces the fixed combinational ROM with a registered-output RAM of configurable depth and width.
- Contents are loaded at run time through a word-write boot port.
- Supports pipeline stall (hold) and flush (inject NOP), and flags misaligned or out-of-range PCs instead of returning undefined data.

## Interface
Parameters:
- DATA_W, default 32: instruction word width.
- ADDR_W, default 32: byte-address (PC) width.
- DEPTH, default 64: number of instruction words; power of two, minimum 4.
- NOP_WORD, default 32'h0000_0000: word injected on flush, error or idle.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  IF enable; 0 = stall (hold outputs).
- flush  in  1  squash: next instruction is NOP_WORD.
- pc  in  ADDR_W  byte address of fetch.
- instruction  out  DATA_W  registered fetched word.
- inst_valid  out  1  instruction is a real fetched word.
- misalign_err  out  1  registered; pc[1:0] != 0 on the sampled fetch.
- oob_err  out  1  registered; word index >= DEPTH on the sampled fetch.
- load_start  in  1  RUN -> LOAD request.
- load_en  in  1  write strobe in LOAD.
- load_addr  in  $clog2(DEPTH)  word index to write.
- load_data  in  DATA_W  word to write.
- load_done  in  1  LOAD -> RUN.
- load_count  out  $clog2(DEPTH)+1  words written in the current LOAD session, saturating at DEPTH.
- running  out  1  FSM is in RUN.

## Operation
FSM states are LOAD and RUN.
- Reset: state = LOAD, or RUN with INST_MEM_INIT_EN.
- Reset values: instruction = NOP_WORD; inst_valid, misalign_err, oob_err = 0; load_count = 0. Array contents are not cleared by reset.

LOAD state:
- load_en writes load_data to word load_addr and increments load_count.
- Fetches are ignored: instruction = NOP_WORD, inst_valid = 0.
- load_done moves the FSM to RUN at the next edge. If load_en and load_done are asserted in the same cycle, the write is performed, then the FSM enters RUN.

RUN state:
- load_en is ignored; the array is unchanged.
- load_start returns the FSM to LOAD, clears load_count, and forces instruction = NOP_WORD with inst_valid = 0.
- load_start has priority over fetch in the same cycle.

Fetch evaluation in RUN, highest priority first:
1. flush: instruction = NOP_WORD, inst_valid = 0, both error flags = 0.
2. !fetch_en: all fetch outputs hold their previous values.
3. pc[1:0] != 0: NOP_WORD, inst_valid = 0, misalign_err = 1.
4. pc[ADDR_W-1:2] >= DEPTH: NOP_WORD, inst_valid = 0, oob_err = 1.
5. Otherwise: instruction = mem[pc[ADDR_W-1:2]], inst_valid = 1, error flags = 0.

Width rules:
- Word index = pc >> 2.
- Out-of-range is checked on the full upper PC bits; there is no wrap-around aliasing.

Reset mid-LOAD: the FSM returns to its reset state and already-written words are retained.

## Timing
- Fetch latency is one cycle: pc sampled at edge N appears on instruction after edge N.
- A stall holds the outputs for as many cycles as fetch_en is low.
- Load write-to-fetch latency:
  - A word written at edge N is fetchable at edge N+1 at the earliest.
  - This requires load_done at edge N and the fetch at edge N+1.
  - That fetch's data appears after edge N+1.
- No read/write collision is possible, because writes occur only in LOAD and fetches only in RUN.
- The running output is registered and equals the current state.

## Configuration
- INST_MEM_INIT_EN defined:
  - The array is preloaded at elaboration with the default diagnostic program, starting at word 0: 20020005, 2003000c, 20070003, 00e22025, ...
  - The remaining words are NOP_WORD.
  - The reset state is RUN.
- INST_MEM_INIT_EN undefined:
  - There is no preload; contents are unknown until written.
  - The reset state is LOAD, and a load session must complete before execution.

## Structure
- Package inst_mem_pkg holds:
  - the state enum (IM_LOAD, IM_RUN);
  - the default NOP constant;
  - the default diagnostic program as a constant array, used under INST_MEM_INIT_EN.
- Sub-module inst_mem_array:
  - simple single-clock RAM of DEPTH x DATA_W;
  - one write port and one registered read port;
  - no reset.
- The top level holds the FSM, fetch priority logic, error flags and load_count.

## Test plan
- No macro: after reset, running = 0. Load word 0 = 20020005 and word 1 = 2003000c, then pulse load_done, giving load_count = 2. Fetch pc = 0 then pc = 4 -> instruction 20020005 then 2003000c, inst_valid = 1 each cycle.
- Stall and flush: fetch pc = 4, then hold fetch_en = 0 for 3 cycles -> 2003000c held with inst_valid = 1. Then pulse flush -> NOP_WORD with inst_valid = 0 on the next cycle.
- Errors with DEPTH = 64:
  - pc = 6 -> misalign_err = 1, NOP_WORD.
  - pc = 256 -> oob_err = 1, NOP_WORD.
  - pc = 252 -> valid fetch, no flags.
- Same-cycle load_en and load_done, writing word 5 = ac670044 -> next cycle running = 1. Fetch pc = 20 -> ac670044.
- Reload: in RUN, pulse load_start -> running = 0 and load_count = 0. load_en is ignored during the transition cycle. Word contents written before the reset are retained across rst_n.
- INST_MEM_INIT_EN defined: reset, then fetch pc = 0, 4, 8 with no load -> 20020005, 2003000c, 20070003.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
//   Shared definitions for the IF-stage instruction memory:
//     - im_state_e   : controller states (IM_LOAD, IM_RUN)
//     - NOP_DEFAULT  : default word returned on flush, error or idle
//     - DIAG_PROG    : default diagnostic program, word 0 first. It is used as
//                      the preload image when INST_MEM_INIT_EN is defined.
// -----------------------------------------------------------------------------
package inst_mem_pkg;

  typedef enum logic {
    IM_LOAD = 1'b0,
    IM_RUN  = 1'b1
  } im_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  localparam int DIAG_LEN = 4;

  // Packed so that DIAG_PROG[i] is program word i.
  localparam logic [DIAG_LEN-1:0][31:0] DIAG_PROG = {
    32'h00e2_2025,
    32'h2007_0003,
    32'h2003_000c,
    32'h2002_0005
  };

endpackage

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
//   Single-clock DEPTH x DATA_W RAM with one write port and one registered read
//   port. The RAM has no reset, so its contents survive rst_n.
//   Optional macro INST_MEM_INIT_EN: the array is preloaded at elaboration with
//   inst_mem_pkg::DIAG_PROG from word 0, and every other word holds NOP_WORD.
//
// Ports
//   clk      in   clock, rising edge
//   we_i     in   write strobe
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   re_i     in   read enable; when low, rdata_o holds its previous value
//   raddr_i  in   read word index
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
`ifdef INST_MEM_INIT_EN
  ,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
`endif
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

`ifdef INST_MEM_INIT_EN
  // DEPTH is at least 4, so all four program words always fit.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{
    0:       DATA_W'(DIAG_PROG[0]),
    1:       DATA_W'(DIAG_PROG[1]),
    2:       DATA_W'(DIAG_PROG[2]),
    3:       DATA_W'(DIAG_PROG[3]),
    default: NOP_WORD
  };
`else
  logic [DATA_W-1:0] mem_q [DEPTH];
`endif

  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_sync.sv
// -----------------------------------------------------------------------------
// inst_mem_sync
//   Registered-output instruction memory for the IF stage. The memory is loaded
//   through a word-write boot port while in LOAD, and it serves fetches while in
//   RUN. Fetch handling supports stall (fetch_en low), flush (inject NOP_WORD),
//   and flags for misaligned and out-of-range PCs.
//   Optional macro INST_MEM_INIT_EN: the array is preloaded with the diagnostic
//   program and the FSM resets into RUN. Without the macro, the FSM resets into
//   LOAD and the array contents are unknown until they are written.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IM_LOAD | boot port writes the array; fetch outputs forced to NOP, invalid
//   IM_RUN  | fetches served with one cycle of latency; boot writes ignored
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   fetch_en, flush   IF enable (low = stall) and squash request
//   pc                byte address of the fetch
//   instruction       registered fetched word (NOP_WORD when not valid)
//   inst_valid        instruction holds a real fetched word
//   misalign_err      pc[1:0] != 0 on the sampled fetch
//   oob_err           word index >= DEPTH on the sampled fetch
//   load_start        RUN -> LOAD request
//   load_en, load_addr, load_data   boot write port (active in LOAD only)
//   load_done         LOAD -> RUN request
//   load_count        words written this LOAD session, saturating at DEPTH
//   running           registered, high while the FSM is in RUN
// -----------------------------------------------------------------------------
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-1:0]        instruction,
  output logic                     inst_valid,
  output logic                     misalign_err,
  output logic                     oob_err,
  input  logic                     load_start,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     running
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(DEPTH);

`ifdef INST_MEM_INIT_EN
  localparam im_state_e RESET_STATE = IM_RUN;
`else
  localparam im_state_e RESET_STATE = IM_LOAD;
`endif

  im_state_e       state_q, state_d;
  logic [IDX_W:0]  count_q, count_d;
  logic            valid_q, valid_d;
  logic            mis_q,   mis_d;
  logic            oob_q,   oob_d;
  logic            rd_en;
  logic            wr_en;
  logic [DATA_W-1:0] rdata;

  // DEPTH is a power of two, so a word index >= DEPTH means that at least one
  // PC bit above the array index is set. Checking every upper bit prevents
  // wrap-around aliasing.
  logic pc_misaligned;
  logic pc_out_of_range;
  assign pc_misaligned   = (pc[1:0] != 2'b00);
  assign pc_out_of_range = |pc[ADDR_W-1:IDX_W+2];

  // Writes are allowed only in LOAD. rst_n gates the write so that a reset
  // cycle cannot disturb the contents that are retained.
  assign wr_en = rst_n && (state_q == IM_LOAD) && load_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    oob_d   = oob_q;
    rd_en   = 1'b0;

    case (state_q)
      IM_LOAD: begin
        valid_d = 1'b0;
        mis_d   = 1'b0;
        oob_d   = 1'b0;
        if (load_en && (count_q != CNT_MAX)) begin
          count_d = count_q + 1'b1;
        end
        if (load_done) begin
          state_d = IM_RUN;
        end
      end

      IM_RUN: begin
        if (load_start) begin
          state_d = IM_LOAD;
          count_d = '0;
          valid_d = 1'b0;
          mis_d   = 1'b0;
          oob_d   = 1'b0;
        end else if (flush) begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
          oob_d   = 1'b0;
        end else if (fetch_en) begin
          if (pc_misaligned) begin
            valid_d = 1'b0;
            mis_d   = 1'b1;
            oob_d   = 1'b0;
          end else if (pc_out_of_range) begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
            oob_d   = 1'b1;
          end else begin
            rd_en   = 1'b1;
            valid_d = 1'b1;
            mis_d   = 1'b0;
            oob_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      count_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      oob_q   <= oob_d;
    end
  end

  inst_mem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W)
`ifdef INST_MEM_INIT_EN
    ,
    .NOP_WORD (NOP_WORD)
`endif
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (pc[IDX_W+1:2]),
    .rdata_o (rdata)
  );

  // The read register is loaded only on a valid fetch and is held otherwise.
  // Masking it with valid_q therefore gives a registered output that returns
  // NOP_WORD on reset, flush, error and LOAD, and holds its value on stall.
  assign instruction  = valid_q ? rdata : NOP_WORD;
  assign inst_valid   = valid_q;
  assign misalign_err = mis_q;
  assign oob_err      = oob_q;
  assign load_count   = count_q;
  assign running      = (state_q == IM_RUN);

endmodule

// File: tb/tb_inst_mem_sync.sv
module tb_inst_mem_sync;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, flush;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        inst_valid, misalign_err, oob_err;
  logic        load_start, load_en, load_done;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [6:0]  load_count;
  logic        running;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  inst_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .flush(flush), .pc(pc),
    .instruction(instruction), .inst_valid(inst_valid),
    .misalign_err(misalign_err), .oob_err(oob_err),
    .load_start(load_start), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .load_count(load_count), .running(running)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_run;
  int          m_count;
  logic [31:0] m_instr;
  bit          m_ik;          // model knows the instruction value
  bit          m_valid, m_mis, m_oob;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

`ifdef INST_MEM_INIT_EN
  localparam bit RST_RUN = 1'b1;
`else
  localparam bit RST_RUN = 1'b0;
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = NOP;
      m_known[i] = 1'b0;
    end
`ifdef INST_MEM_INIT_EN
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b1;
    m_mem[0] = 32'h20020005;
    m_mem[1] = 32'h2003000c;
    m_mem[2] = 32'h20070003;
    m_mem[3] = 32'h00e22025;
`endif
  end

  task automatic m_nop(input bit mis, input bit oob);
    m_instr = NOP; m_ik = 1'b1; m_valid = 1'b0; m_mis = mis; m_oob = oob;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = RST_RUN; m_count = 0; m_nop(0, 0);
    end else if (!m_run) begin
      if (load_en) begin
        m_mem[load_addr] = load_data;
        m_known[load_addr] = 1'b1;
        if (m_count < DEPTH) m_count++;
      end
      m_nop(0, 0);
      if (load_done) m_run = 1'b1;
    end else if (load_start) begin
      m_run = 1'b0; m_count = 0; m_nop(0, 0);
    end else if (flush) begin
      m_nop(0, 0);
    end else if (fetch_en) begin
      if (pc % 4 != 0)            m_nop(1, 0);
      else if (pc / 4 >= DEPTH)   m_nop(0, 1);
      else begin
        m_instr = m_mem[pc / 4]; m_ik = m_known[pc / 4];
        m_valid = 1'b1; m_mis = 1'b0; m_oob = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("running", running, m_run);
      chk("load_count", load_count, m_count);
      chk("inst_valid", inst_valid, m_valid);
      chk("misalign_err", misalign_err, m_mis);
      chk("oob_err", oob_err, m_oob);
      if (m_ik) chk("instruction", instruction, m_instr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    fetch_en = 0; flush = 0; pc = 0; load_start = 0; load_en = 0;
    load_done = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); fetch_en = 1; pc = a; cyc();
  endtask

  initial begin
    rst_n = 0; idle();
    cyc(); cyc();
    chk_on = 1'b1;
    chk("rst instruction", instruction, NOP);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst load_count", load_count, 0);
    rst_n = 1;

`ifdef INST_MEM_INIT_EN
    chk("rst running", running, 1);
    fetch(0);  chk("pre w0", instruction, 32'h20020005);
    fetch(4);  chk("pre w1", instruction, 32'h2003000c);
    fetch(8);  chk("pre w2", instruction, 32'h20070003);
    chk("pre valid", inst_valid, 1);
`else
    chk("rst running", running, 0);
    idle(); load_en = 1; load_addr = 0; load_data = 32'h20020005; cyc();
    load_addr = 1; load_data = 32'h2003000c; cyc();
    idle(); load_done = 1; cyc();
    chk("load running", running, 1);
    chk("load count 2", load_count, 2);
    fetch(0); chk("fetch w0", instruction, 32'h20020005); chk("fetch w0 valid", inst_valid, 1);
    fetch(4); chk("fetch w1", instruction, 32'h2003000c); chk("fetch w1 valid", inst_valid, 1);
    // stall 3 cycles with a different pc on the bus
    for (int i = 0; i < 3; i++) begin
      idle(); pc = 0; cyc();
      chk("stall hold", instruction, 32'h2003000c);
      chk("stall valid", inst_valid, 1);
    end
    idle(); flush = 1; fetch_en = 1; pc = 0; cyc();
    chk("flush nop", instruction, NOP); chk("flush valid", inst_valid, 0);
    fetch(6);   chk("pc6 misalign", misalign_err, 1); chk("pc6 nop", instruction, NOP);
    fetch(256); chk("pc256 oob", oob_err, 1); chk("pc256 mis", misalign_err, 0);
    chk("pc256 nop", instruction, NOP);
    fetch(252); chk("pc252 valid", inst_valid, 1); chk("pc252 oob", oob_err, 0);
    // reload; load_en during the load_start cycle must be ignored
    idle(); load_start = 1; load_en = 1; load_addr = 5; load_data = 32'hdeadbeef; cyc();
    chk("reload running", running, 0); chk("reload count", load_count, 0);
    idle(); load_en = 1; load_addr = 5; load_data = 32'hac670044; load_done = 1; cyc();
    chk("same-cycle running", running, 1); chk("same-cycle count", load_count, 1);
    fetch(20); chk("fetch w5", instruction, 32'hac670044);
    // reset retention
    idle(); rst_n = 0; cyc(); rst_n = 1;
    chk("rst2 running", running, 0);
    idle(); load_done = 1; cyc();
    fetch(0); chk("retained w0", instruction, 32'h20020005);
`endif

    // full load with saturation
    idle(); load_start = 1; cyc();
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle(); load_en = 1; load_addr = 6'(i); load_data = $urandom; cyc();
    end
    chk("count saturates", load_count, DEPTH);
    idle(); load_done = 1; cyc();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst_n      = ($urandom_range(0, 99) != 0);
      fetch_en   = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      load_start = ($urandom_range(0, 29) == 0);
      load_en    = ($urandom_range(0, 1) == 0);
      load_done  = ($urandom_range(0, 4) == 0);
      load_addr  = 6'($urandom);
      load_data  = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
        3:       pc = 32'($urandom_range(0, 300));
        4:       pc = $urandom;
        default: case ($urandom_range(0, 3))
                   0: pc = 252; 1: pc = 256; 2: pc = 254; default: pc = 32'h8000_0000;
                 endcase
      endcase
      cyc();
    end

    idle(); cyc();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
